// File: rtl/register_file.sv
// 8x32 register file: two combinational read ports, one synchronous write port.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic              clk,
    input  logic              rst
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // An unknown we evaluates false here, so no entry is disturbed by it.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
        if (we && !rst && (ra1 == wa)) begin
            rd1 = wd;
        end
        if (we && !rst && (ra2 == wa)) begin
            rd2 = wd;
        end
    end
`else
    always_comb begin
        rd1 = mem_q[ra1];
        rd2 = mem_q[ra2];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations are hand-computed.
// Builds with or without REG_FILE_BYPASS_EN.
module tb_register_file;

    logic [2:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we, clk, rst;

    int unsigned tests;
    int unsigned fails;

    register_file #(.DATA_W(32), .ADDR_W(3)) dut (
        .ra1(ra1), .ra2(ra2), .wa(wa),
        .rd1(rd1), .rd2(rd2), .wd(wd),
        .we(we), .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0]  ch_a [7];
        logic [31:0] ch_d [7];
        logic [3:0]  wide;

        tests = 0;
        fails = 0;
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        // Fill every entry with all-ones
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); wd = 32'hFFFF_FFFF;
            tick();
            ra1 = 3'(i);
            #1 check("fill", rd1, 32'hFFFF_FFFF);
        end

        // Reset clears everything
        we = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            check("reset_rd1", rd1, 32'h0);
            check("reset_rd2", rd2, 32'h0);
        end

        // Write/readback chain
        ch_a = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2, 3'd7};
        ch_d = '{32'hAAAA_AAAA, 32'h5555_5555, 32'h1234_5678, 32'h8765_4321,
                 32'h1111_1111, 32'h2222_2222, 32'h7777_7777};
        for (int k = 0; k < 7; k++) begin
            we = 1'b1; wa = ch_a[k]; wd = ch_d[k];
            tick();
            ra1 = ch_a[k];
            ra2 = (k == 0) ? 3'd0 : ch_a[k-1];
            #1;
            check("chain_rd1", rd1, ch_d[k]);
            check("chain_rd2", rd2, (k == 0) ? 32'h0 : ch_d[k-1]);
        end

        // Write disable
        we = 1'b0;
        wa = 3'd1; wd = 32'h1112_2111; tick();
        wa = 3'd2; wd = 32'hBBBC_CBBB; tick();
        wa = 3'd3; wd = 32'hCCCD_DCCC; tick();
        ra1 = 3'd1; ra2 = 3'd2; #1;
        check("we0_e1", rd1, 32'h1111_1111);
        check("we0_e2", rd2, 32'h2222_2222);
        ra1 = 3'd3; #1;
        check("we0_e3", rd1, 32'hAAAA_AAAA);

        // Address truncation
        wide = 4'd9;  ra1 = wide[2:0];
        wide = 4'd10; ra2 = wide[2:0];
        #1;
        check("trunc_rd1", rd1, 32'h1111_1111);
        check("trunc_rd2", rd2, 32'h2222_2222);
        wide = 4'd8;
        we = 1'b1; wa = wide[2:0]; wd = 32'hA5A5_0F0F;
        tick();
        we = 1'b0; ra1 = 3'd0; #1;
        check("trunc_wr0", rd1, 32'hA5A5_0F0F);

        // Same-cycle read/write on entry 4
        we = 1'b1; wa = 3'd4; wd = 32'hDEAD_BEEF; ra1 = 3'd4; ra2 = 3'd4;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("rdw_pre1", rd1, 32'hDEAD_BEEF);
        check("rdw_pre2", rd2, 32'hDEAD_BEEF);
`else
        check("rdw_pre1", rd1, 32'h5555_5555);
        check("rdw_pre2", rd2, 32'h5555_5555);
`endif
        tick();
        we = 1'b0; #1;
        check("rdw_post1", rd1, 32'hDEAD_BEEF);
        check("rdw_post2", rd2, 32'hDEAD_BEEF);

        // Reset wins over a same-edge write
        rst = 1'b1; we = 1'b1; wa = 3'd6; wd = 32'h1234_5678; ra1 = 3'd6; ra2 = 3'd4;
        #1;
        check("rstpri_pre", rd1, 32'h8765_4321);
        tick();
        rst = 1'b0; we = 1'b0; #1;
        check("rstpri_e6", rd1, 32'h0);
        check("rstpri_e4", rd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
